// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Optional PIPE_PERF_EN adds saturating stall/bubble/flush counters.
module pipe_stage_skid #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 24,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic                in_ready_q, in_ready_d;
    logic                in_fire, out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    state_d     = ONE;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire) begin
                        state_d     = FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_fire) begin
                        state_d     = EMPTY;
                        main_data_d = '0;
                        main_ctrl_d = '0;
                    end
                end
                FULL: if (out_fire) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    skid_data_d = '0;
                    skid_ctrl_d = '0;
                end
                default: state_d = EMPTY;
            endcase
        end
        // Registered ready: only the skid being occupied next cycle blocks upstream.
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
        end
    end

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_q, bubble_q, flush_q;
    logic             killed;

    // A main entry leaving downstream this cycle is consumed, not killed.
    assign killed = (out_valid & ~out_ready) | (state_q == FULL) | in_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            if (out_valid && !out_ready && stall_q != '1) stall_q  <= stall_q + CNT_W'(1);
            if (!out_valid && bubble_q != '1)             bubble_q <= bubble_q + CNT_W'(1);
            if (flush && killed && flush_q != '1)         flush_q  <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flush_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, reset/saturation sequences, random vs queue model.
module tb_pipe_stage_skid;
    localparam int DW   = 160;
    localparam int CW   = 24;
    localparam int NW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt, bubble_cnt, flush_cnt;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    typedef struct {
        bit         iv, fl, ordy;
        logic [7:0] d;
        bit         ev;
        logic [7:0] ed;
        bit         erdy;
    } vec_t;

    ent_t mq[$];
    int   m_st, m_bu, m_fl;
    int   errs = 0, checks = 0;
    vec_t tbl[18];

    function automatic logic [CW-1:0] ctl(logic [7:0] d);
        return {16'h0, d ^ 8'h5A};
    endfunction

    function automatic vec_t mk(bit iv, bit fl, bit ordy, logic [7:0] d, bit ev, logic [7:0] ed, bit erdy);
        vec_t v;
        v.iv = iv; v.fl = fl; v.ordy = ordy; v.d = d; v.ev = ev; v.ed = ed; v.erdy = erdy;
        return v;
    endfunction

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most two entries; ready means room for one more.
    task automatic model_step();
        bit mv, ifire, ofire;
        ent_t e, dummy;
        mv    = mq.size() > 0;
        ifire = in_valid && (mq.size() < 2);
        ofire = mv && out_ready;
        if (mv && !out_ready && m_st < CMAX) m_st++;
        if (!mv && m_bu < CMAX) m_bu++;
        if (flush && ((mv && !out_ready) || mq.size() == 2 || ifire) && m_fl < CMAX) m_fl++;
        if (flush) mq.delete();
        else begin
            if (ofire) dummy = mq.pop_front();
            if (ifire) begin
                e.d = in_data; e.c = in_ctrl;
                mq.push_back(e);
            end
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_st = 0; m_bu = 0; m_fl = 0;
    endtask

    task automatic check_model();
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        ed = (mq.size() > 0) ? mq[0].d : '0;
        ec = (mq.size() > 0) ? mq[0].c : '0;
        chk("m_out_valid", DW'(out_valid), DW'(mq.size() > 0));
        chk("m_in_ready", DW'(in_ready), DW'(mq.size() < 2));
        chk("m_out_data", out_data, ed);
        chk("m_out_ctrl", DW'(out_ctrl), DW'(ec));
`ifdef PIPE_PERF_EN
        chk("m_stall_cnt", DW'(stall_cnt), DW'(m_st));
        chk("m_bubble_cnt", DW'(bubble_cnt), DW'(m_bu));
        chk("m_flush_cnt", DW'(flush_cnt), DW'(m_fl));
`else
        chk("m_stall_cnt", DW'(stall_cnt), '0);
        chk("m_bubble_cnt", DW'(bubble_cnt), '0);
        chk("m_flush_cnt", DW'(flush_cnt), '0);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_step();
        #1;
        check_model();
    endtask

    task automatic drive(bit iv, bit fl, bit ordy, logic [DW-1:0] d, logic [CW-1:0] c);
        @(negedge clk);
        in_valid = iv; flush = fl; out_ready = ordy; in_data = d; in_ctrl = c;
    endtask

    initial begin
        // Expected state after each edge, computed by hand from the handshake rules.
        tbl[0]  = mk(1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 8'h11, 1'b1);
        tbl[1]  = mk(1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 8'h22, 1'b1);
        tbl[2]  = mk(1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 8'h33, 1'b1);
        tbl[3]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 8'hA1, 1'b1, 8'hA1, 1'b1);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 8'hA2, 1'b1, 8'hA1, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 1'b0, 8'hA3, 1'b1, 8'hA1, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA2, 1'b1);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 8'hB1, 1'b1, 8'hB1, 1'b1);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 8'hB2, 1'b1, 8'hB1, 1'b0);
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 8'hB3, 1'b0, 8'h00, 1'b1);
        tbl[12] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        tbl[13] = mk(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 8'hC1, 1'b1, 8'hC1, 1'b1);
        tbl[15] = mk(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        tbl[16] = mk(1'b1, 1'b1, 1'b1, 8'hD1, 1'b0, 8'h00, 1'b1);
        tbl[17] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);

        // Reset asserted mid-clock must clear outputs without waiting for an edge.
        #3 reset = 1'b1;
        #1;
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_ctrl", DW'(out_ctrl), '0);
        chk("rst_in_ready", DW'(in_ready), DW'(1'b1));
        model_reset();
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].iv, tbl[i].fl, tbl[i].ordy, DW'(tbl[i].d), ctl(tbl[i].d));
            cycle();
            chk($sformatf("tbl%0d_valid", i), DW'(out_valid), DW'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i), out_data, DW'(tbl[i].ed));
            chk($sformatf("tbl%0d_ctrl", i), DW'(out_ctrl), tbl[i].ev ? DW'(ctl(tbl[i].ed)) : '0);
            chk($sformatf("tbl%0d_ready", i), DW'(in_ready), DW'(tbl[i].erdy));
        end

        // Stall saturation: one entry held for 20 cycles.
        drive(1'b1, 1'b0, 1'b0, DW'(8'hE1), ctl(8'hE1));
        cycle();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0);
            cycle();
        end
`ifdef PIPE_PERF_EN
        chk("stall_sat", DW'(stall_cnt), DW'(CMAX));
`else
        chk("stall_off", DW'(stall_cnt), '0);
`endif
        chk("stall_hold_data", out_data, DW'(8'hE1));
        drive(1'b1, 1'b0, 1'b0, DW'(8'hE2), ctl(8'hE2));
        cycle();

        // Reset mid-operation with the stage FULL: everything disappears at once.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst2_out_valid", DW'(out_valid), '0);
        chk("rst2_out_data", out_data, '0);
        chk("rst2_out_ctrl", DW'(out_ctrl), '0);
        chk("rst2_in_ready", DW'(in_ready), DW'(1'b1));
        chk("rst2_stall_cnt", DW'(stall_cnt), '0);
        model_reset();
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(1, 0) == 1, $urandom_range(15, 0) == 0, $urandom_range(3, 0) != 0,
                  {$urandom, $urandom, $urandom, $urandom, $urandom}, CW'($urandom));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
